// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types, frame geometry, stage states and gain ramp helper
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    localparam int          FRAME_LEN   = 32;
    localparam int          GAIN_LANES  = 8;
    localparam int          LANE_CYCLES = FRAME_LEN / GAIN_LANES;
    localparam logic [15:0] UNITY_GAIN  = 16'h4000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PROC   = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    // One ramp step from cur toward tgt, landing exactly on tgt when within a step.
    function automatic logic [15:0] ramp_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt,
                                                input logic [15:0] step);
        logic [15:0] diff;
        if (cur < tgt) begin
            diff        = tgt - cur;
            ramp_toward = (diff <= step) ? tgt : cur + step;
        end else begin
            diff        = cur - tgt;
            ramp_toward = (diff <= step) ? tgt : cur - step;
        end
    endfunction

endpackage

// File: rtl/frame_gain_if.sv
// rtl/frame_gain_if.sv - done/ready frame handshake bundle between effect stages
interface frame_gain_if;
    import audio_pkg::*;

    logic        prev_module_done;
    logic        next_module_ready;
    logic [31:0] address_in;
    sample_t     audio_in [FRAME_LEN];
    logic [31:0] address_out;
    sample_t     audio_out [FRAME_LEN];
    logic        ready_for_data;
    logic        done;

    modport master (
        output prev_module_done, next_module_ready, address_in, audio_in,
        input  address_out, audio_out, ready_for_data, done
    );

    modport slave (
        input  prev_module_done, next_module_ready, address_in, audio_in,
        output address_out, audio_out, ready_for_data, done
    );

endinterface

// File: rtl/gain_sat_mul.sv
// rtl/gain_sat_mul.sv - one lane: signed sample x unsigned Q2.14 gain, round half up, saturate
module gain_sat_mul
    import audio_pkg::*;
(
    input  sample_t     i_sample,
    input  logic [15:0] i_gain,
    output sample_t     o_sample
);

    logic signed [33:0] w_sample_x;
    logic signed [33:0] w_gain_x;
    logic signed [33:0] w_prod;
    logic signed [33:0] w_shift;

    // Product magnitude stays below 2^31, so a 34-bit multiply is exact.
    assign w_sample_x = {{18{i_sample[15]}}, i_sample};
    assign w_gain_x   = {18'b0, i_gain};
    assign w_prod     = w_sample_x * w_gain_x;
    assign w_shift    = (w_prod + 34'sd8192) >>> 14;

    always_comb begin
        o_sample = w_shift[15:0];
        if (w_shift > 34'sd32767) begin
            o_sample = 16'sh7fff;
        end else if (w_shift < -34'sd32768) begin
            o_sample = 16'sh8000;
        end
    end

endmodule

// File: rtl/frame_gain.sv
// rtl/frame_gain.sv - per-frame gain stage, 8 lanes x 4 cycles; FRAME_GAIN_RAMP_EN enables gain ramping
module frame_gain
    import audio_pkg::*;
#(
    parameter logic [15:0] RAMP_STEP = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] gain_target,
    input  logic        gain_load,
    frame_gain_if.slave bus
);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_lane;
    sample_t     r_frame [FRAME_LEN];
    sample_t     r_out [FRAME_LEN];
    sample_t     w_lane_out [GAIN_LANES];
    logic [31:0] r_addr;
    logic [31:0] r_addr_out;
    logic [15:0] r_frame_gain;
    logic [15:0] r_gain_cur;
    logic [15:0] r_gain_tgt;
    logic [15:0] w_cap_gain;
    logic        w_capture;
    logic        w_release;

    assign w_capture = (r_state == S_IDLE) && bus.prev_module_done;
    assign w_release = (r_state == S_OUTPUT) && bus.next_module_ready;

    assign bus.ready_for_data = (r_state == S_IDLE);
    assign bus.done           = (r_state == S_OUTPUT);
    assign bus.audio_out      = r_out;
    assign bus.address_out    = r_addr_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_capture) w_state_nxt = S_PROC;
            S_PROC:   if (r_lane == 2'(LANE_CYCLES - 1)) w_state_nxt = S_OUTPUT;
            S_OUTPUT: if (w_release) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_frame      <= bus.audio_in;
            r_addr       <= bus.address_in;
            r_frame_gain <= w_cap_gain;
        end
    end

    for (genvar g = 0; g < GAIN_LANES; g++) begin : g_lane
        localparam logic [2:0] LG = 3'(g);
        gain_sat_mul u_mul (
            .i_sample (r_frame[{r_lane, LG}]),
            .i_gain   (r_frame_gain),
            .o_sample (w_lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane     <= 2'd0;
            r_addr_out <= 32'd0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_out[i] <= 16'sd0;
            end
        end else if (w_capture) begin
            r_lane <= 2'd0;
        end else if (r_state == S_PROC) begin
            r_lane     <= r_lane + 2'd1;
            r_addr_out <= r_addr;
            for (int g = 0; g < GAIN_LANES; g++) begin
                r_out[{r_lane, 3'(g)}] <= en ? w_lane_out[g] : r_frame[{r_lane, 3'(g)}];
            end
        end
    end

`ifdef FRAME_GAIN_RAMP_EN
    assign w_cap_gain = r_gain_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain_tgt <= UNITY_GAIN;
            r_gain_cur <= UNITY_GAIN;
        end else begin
            if (gain_load) r_gain_tgt <= gain_target;
            if (w_release) r_gain_cur <= ramp_toward(r_gain_cur, r_gain_tgt, RAMP_STEP);
        end
    end
`else
    logic [15:0] w_unused_ramp_step;
    assign w_unused_ramp_step = RAMP_STEP;

    // Capture takes the target directly so a load reaches the very next frame.
    assign w_cap_gain = r_gain_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain_tgt <= UNITY_GAIN;
            r_gain_cur <= UNITY_GAIN;
        end else begin
            if (gain_load) r_gain_tgt <= gain_target;
            if (w_capture) r_gain_cur <= r_gain_tgt;
        end
    end
`endif

endmodule

// File: tb/tb_frame_gain.sv
// tb/tb_frame_gain.sv - directed self-checking bench for frame_gain
module tb_frame_gain;
    import audio_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] gain_target;
    logic        gain_load;
    sample_t     stim [FRAME_LEN];
    int          n_checks;
    int          n_errors;

    frame_gain_if bus();

    frame_gain #(.RAMP_STEP(16'h1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .gain_target (gain_target),
        .gain_load   (gain_load),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_gain(input logic [15:0] g);
        gain_target = g;
        gain_load   = 1'b1;
        tick();
        gain_load   = 1'b0;
    endtask

    task automatic capture(input logic [31:0] addr);
        bus.audio_in         = stim;
        bus.address_in       = addr;
        bus.prev_module_done = 1'b1;
        tick();
        bus.prev_module_done = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        bus.next_module_ready = 1'b1;
        tick();
        bus.next_module_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.ready_for_data !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_ready: got %b expected 1", bus.ready_for_data);
        end
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_done: got %b expected 0", bus.done);
        end
        n_checks++;
        if (bus.address_out !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_addr: got %h expected 0", bus.address_out);
        end
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_checks++;
            if (bus.audio_out[i] !== 16'sd0) begin
                n_errors++;
                $display("FAIL reset_audio[%0d]: got %0d expected 0", i, bus.audio_out[i]);
            end
        end
    endtask

    task automatic test_unity();
        int lat;
        en = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = sample_t'(100 * i - 1600);
        capture(32'hA000_0040);
        n_checks++;
        if (bus.ready_for_data !== 1'b0) begin
            n_errors++;
            $display("FAIL unity_busy: ready got %b expected 0", bus.ready_for_data);
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 5) begin
            n_errors++;
            $display("FAIL unity_latency: got %0d expected 5", lat);
        end
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_checks++;
            if (bus.audio_out[i] !== sample_t'(100 * i - 1600)) begin
                n_errors++;
                $display("FAIL unity_audio[%0d]: got %0d expected %0d", i, bus.audio_out[i], 100 * i - 1600);
            end
        end
        n_checks++;
        if (bus.address_out !== 32'hA000_0040) begin
            n_errors++;
            $display("FAIL unity_addr: got %h expected a0000040", bus.address_out);
        end
        release_out();
    endtask

    task automatic test_gain2();
        int      lat;
        sample_t exp_v [6];
        exp_v = '{16'sd200, 16'sd32767, 16'sh8000, -16'sd2, 16'sd32767, 16'sh8000};
        load_gain(16'h8000);
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'sd0;
        stim[0] = 16'sd100;
        stim[1] = 16'sd20000;
        stim[2] = -16'sd20000;
        stim[3] = -16'sd1;
        stim[4] = 16'sd16384;
        stim[5] = -16'sd16384;
        capture(32'h0000_0100);
        wait_done(lat);
        n_checks++;
        if (lat !== 5) begin
            n_errors++;
            $display("FAIL gain2_latency: got %0d expected 5", lat);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.audio_out[i] !== exp_v[i]) begin
                n_errors++;
                $display("FAIL gain2_audio[%0d]: got %0d expected %0d", i, bus.audio_out[i], exp_v[i]);
            end
        end
        n_checks++;
        if (bus.audio_out[31] !== 16'sd0) begin
            n_errors++;
            $display("FAIL gain2_zero: got %0d expected 0", bus.audio_out[31]);
        end
        release_out();
    endtask

    task automatic test_round();
        int      lat;
        sample_t in_v [7];
        sample_t exp_v [7];
        in_v  = '{16'sd3, -16'sd3, 16'sd1, -16'sd1, 16'sd2, -16'sd2, 16'sd32767};
        exp_v = '{16'sd2, -16'sd1, 16'sd1, 16'sd0, 16'sd1, -16'sd1, 16'sd16384};
        load_gain(16'h2000);
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'sd0;
        for (int i = 0; i < 7; i++) stim[i * 5] = in_v[i];
        capture(32'h0000_0200);
        wait_done(lat);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (bus.audio_out[i * 5] !== exp_v[i]) begin
                n_errors++;
                $display("FAIL round_audio[%0d]: got %0d expected %0d", i * 5, bus.audio_out[i * 5], exp_v[i]);
            end
        end
        release_out();
    endtask

    task automatic test_bypass();
        int      lat;
        sample_t in_v [4];
        in_v = '{16'sd3, 16'sh8000, 16'sd32767, -16'sd3};
        en = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'sd0;
        for (int i = 0; i < 4; i++) stim[i * 9] = in_v[i];
        capture(32'h0000_0300);
        wait_done(lat);
        n_checks++;
        if (lat !== 5) begin
            n_errors++;
            $display("FAIL bypass_latency: got %0d expected 5", lat);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.audio_out[i * 9] !== in_v[i]) begin
                n_errors++;
                $display("FAIL bypass_audio[%0d]: got %0d expected %0d", i * 9, bus.audio_out[i * 9], in_v[i]);
            end
        end
        release_out();
        en = 1'b1;
    endtask

    task automatic test_backpressure();
        int lat;
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = sample_t'(i * 7 - 50);
        capture(32'h0000_1234);
        wait_done(lat);
        n_checks++;
        if (lat !== 5) begin
            n_errors++;
            $display("FAIL bp_latency: got %0d expected 5", lat);
        end
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < FRAME_LEN; i++) bus.audio_in[i] = sample_t'(c * 100 + i);
            bus.address_in       = 32'h0000_DEAD;
            bus.prev_module_done = 1'b1;
            tick();
            n_checks++;
            if (bus.done !== 1'b1 || bus.ready_for_data !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: done %b ready %b expected 1 0", c, bus.done, bus.ready_for_data);
            end
            n_checks++;
            if (bus.audio_out[0] !== -16'sd50 || bus.audio_out[31] !== 16'sd167) begin
                n_errors++;
                $display("FAIL bp_audio[%0d]: got %0d %0d expected -50 167", c, bus.audio_out[0], bus.audio_out[31]);
            end
            n_checks++;
            if (bus.address_out !== 32'h0000_1234) begin
                n_errors++;
                $display("FAIL bp_addr[%0d]: got %h expected 00001234", c, bus.address_out);
            end
        end
        bus.prev_module_done = 1'b0;
        release_out();
        tick();
        n_checks++;
        if (bus.ready_for_data !== 1'b1 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_after: ready %b done %b expected 1 0", bus.ready_for_data, bus.done);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        load_gain(16'h8000);
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'sd1000;
        capture(32'h0000_0077);
        tick();
        tick();
        n_checks++;
        if (bus.audio_out[0] !== 16'sd2000) begin
            n_errors++;
            $display("FAIL rstmid_pre: got %0d expected 2000", bus.audio_out[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.ready_for_data !== 1'b1 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_state: ready %b done %b expected 1 0", bus.ready_for_data, bus.done);
        end
        n_checks++;
        if (bus.audio_out[0] !== 16'sd0 || bus.audio_out[8] !== 16'sd0) begin
            n_errors++;
            $display("FAIL rstmid_audio: got %0d %0d expected 0 0", bus.audio_out[0], bus.audio_out[8]);
        end
        n_checks++;
        if (bus.address_out !== 32'd0) begin
            n_errors++;
            $display("FAIL rstmid_addr: got %h expected 0", bus.address_out);
        end
        capture(32'h0000_0078);
        wait_done(lat);
        n_checks++;
        if (lat !== 5) begin
            n_errors++;
            $display("FAIL rstmid_latency: got %0d expected 5", lat);
        end
        n_checks++;
        if (bus.audio_out[0] !== 16'sd1000 || bus.audio_out[31] !== 16'sd1000) begin
            n_errors++;
            $display("FAIL rstmid_unity: got %0d %0d expected 1000 1000", bus.audio_out[0], bus.audio_out[31]);
        end
        release_out();
    endtask

`ifdef FRAME_GAIN_RAMP_EN
    task automatic test_ramp();
        int      lat;
        sample_t exp_v [6];
        exp_v = '{16'sd1000, 16'sd750, 16'sd500, 16'sd250, 16'sd0, 16'sd0};
        load_gain(16'h0000);
        for (int i = 0; i < FRAME_LEN; i++) stim[i] = 16'sd0;
        stim[0] = 16'sd1000;
        for (int f = 0; f < 6; f++) begin
            capture(32'h0000_0400);
            wait_done(lat);
            n_checks++;
            if (bus.audio_out[0] !== exp_v[f]) begin
                n_errors++;
                $display("FAIL ramp_frame[%0d]: got %0d expected %0d", f, bus.audio_out[0], exp_v[f]);
            end
            release_out();
        end
    endtask
`endif

    initial begin
        n_checks              = 0;
        n_errors              = 0;
        rst                   = 1'b1;
        en                    = 1'b1;
        gain_target           = 16'h4000;
        gain_load             = 1'b0;
        bus.prev_module_done  = 1'b0;
        bus.next_module_ready = 1'b0;
        bus.address_in        = 32'd0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            bus.audio_in[i] = 16'sd0;
            stim[i]         = 16'sd0;
        end
        test_reset();
        test_unity();
`ifdef FRAME_GAIN_RAMP_EN
        test_ramp();
        test_reset();
        test_backpressure();
`else
        test_gain2();
        test_round();
        test_bypass();
        test_reset();
        test_backpressure();
        test_rst_mid();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
